// File: rtl/cmd_turnaround_pkg.sv
// Shared types and helpers for the CMD bus turnaround tracker.
// The state struct is sized for the largest supported channel so that one
// blocking rule serves every instance; narrower channels zero-fill the rest.
package cmd_turnaround_pkg;

    localparam int MAX_RANKS  = 16;
    localparam int MAX_RANK_W = 4;
    localparam int MAX_CNT_W  = 16;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_type_e;

    typedef struct packed {
        logic                                  last_valid;
        logic [MAX_RANK_W-1:0]                 last_rank;
        cmd_type_e                             last_cmd;
        logic [MAX_CNT_W-1:0]                  rtr_cnt;
        logic [MAX_CNT_W-1:0]                  rtw_cnt;
        logic [MAX_RANKS-1:0][MAX_CNT_W-1:0]   wtr_cnt;
    } turnaround_state_t;

    // Rank index width; a single bit even for degenerate rank counts.
    function automatic int rank_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width large enough to hold the longest window without overflow.
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

    // A candidate is blocked while any window relevant to it is still open.
    function automatic logic is_blocked(turnaround_state_t s,
                                        logic [MAX_RANK_W-1:0] rank,
                                        cmd_type_e cmd);
        logic rank_switch;
        logic rd_to_wr;
        logic wr_to_rd;
        rank_switch = s.last_valid && (rank != s.last_rank) && (s.rtr_cnt != '0);
        rd_to_wr    = (cmd == CMD_WR) && (s.rtw_cnt != '0);
        wr_to_rd    = (cmd == CMD_RD) && (s.wtr_cnt[rank] != '0);
        return rank_switch || rd_to_wr || wr_to_rd;
    endfunction

endpackage

// File: rtl/cmd_turnaround_channel.sv
// One channel: last-command record, three turnaround window counters and a
// sticky violation flag. Query and violation check share is_blocked().
module cmd_turnaround_channel
    import cmd_turnaround_pkg::*;
#(
    parameter int  NUM_RANKS = 4,
    parameter int  tRTRS     = 2,
    parameter int  tRTW      = 4,
    parameter int  tWTR      = 6,
    localparam int RANK_W    = rank_width(NUM_RANKS),
    localparam int CNT_W     = cnt_width(tRTRS, tRTW, tWTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    input  logic [RANK_W-1:0] issue_rank_i,
    input  logic              issue_is_write_i,
    input  logic [RANK_W-1:0] req_rank_i,
    input  logic              req_is_write_i,
    output logic              req_free_o,
    output logic              bus_quiet_o,
    output logic              violation_o
);

    logic                            last_valid_q, last_valid_d;
    logic [RANK_W-1:0]               last_rank_q,  last_rank_d;
    cmd_type_e                       last_cmd_q,   last_cmd_d;
    logic [CNT_W-1:0]                rtr_cnt_q,    rtr_cnt_d;
    logic [CNT_W-1:0]                rtw_cnt_q,    rtw_cnt_d;
    logic [NUM_RANKS-1:0][CNT_W-1:0] wtr_cnt_q,    wtr_cnt_d;
    logic                            violation_q,  violation_d;

    turnaround_state_t cur_state;
    logic              issue_blocked;

    function automatic logic [CNT_W-1:0] dec_sat(logic [CNT_W-1:0] c);
        return (c != '0) ? c - CNT_W'(1) : c;
    endfunction

    // Widen the registered state into the shared struct view.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cur_state            = '0;
        cur_state.last_valid = last_valid_q;
        cur_state.last_rank  = MAX_RANK_W'(last_rank_q);
        cur_state.last_cmd   = last_cmd_q;
        cur_state.rtr_cnt    = MAX_CNT_W'(rtr_cnt_q);
        cur_state.rtw_cnt    = MAX_CNT_W'(rtw_cnt_q);
        for (int r = 0; r < NUM_RANKS; r++) begin
            cur_state.wtr_cnt[r] = MAX_CNT_W'(wtr_cnt_q[r]);
        end
    end

    // Query and issue checks both see pre-issue state only.
    always_comb begin
        issue_blocked = is_blocked(cur_state, MAX_RANK_W'(issue_rank_i),
                                   cmd_type_e'(issue_is_write_i));
        req_free_o    = !is_blocked(cur_state, MAX_RANK_W'(req_rank_i),
                                    cmd_type_e'(req_is_write_i));
        bus_quiet_o   = (rtr_cnt_q == '0) && (rtw_cnt_q == '0) && (wtr_cnt_q == '0);
        violation_o   = violation_q;
    end

    // Next state: counters drain by one; an issue reloads the windows it opens.
    always_comb begin
        last_valid_d = last_valid_q;
        last_rank_d  = last_rank_q;
        last_cmd_d   = last_cmd_q;
        rtr_cnt_d    = dec_sat(rtr_cnt_q);
        rtw_cnt_d    = dec_sat(rtw_cnt_q);
        violation_d  = violation_q;
        for (int r = 0; r < NUM_RANKS; r++) begin
            wtr_cnt_d[r] = dec_sat(wtr_cnt_q[r]);
            if (issue_valid_i && issue_is_write_i && (issue_rank_i == RANK_W'(r))) begin
                wtr_cnt_d[r] = CNT_W'(tWTR);
            end
        end
        if (issue_valid_i) begin
            last_valid_d = 1'b1;
            last_rank_d  = issue_rank_i;
            last_cmd_d   = cmd_type_e'(issue_is_write_i);
            rtr_cnt_d    = CNT_W'(tRTRS);
            if (!issue_is_write_i) begin
                rtw_cnt_d = CNT_W'(tRTW);
            end
            if (issue_blocked) begin
                violation_d = 1'b1;
            end
        end
    end

    // State registers; reset closes every window at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (!rst) begin
            last_valid_q <= 1'b0;
            last_rank_q  <= '0;
            last_cmd_q   <= CMD_RD;
            rtr_cnt_q    <= '0;
            rtw_cnt_q    <= '0;
            wtr_cnt_q    <= '0;
            violation_q  <= 1'b0;
        end else begin
            last_valid_q <= last_valid_d;
            last_rank_q  <= last_rank_d;
            last_cmd_q   <= last_cmd_d;
            rtr_cnt_q    <= rtr_cnt_d;
            rtw_cnt_q    <= rtw_cnt_d;
            wtr_cnt_q    <= wtr_cnt_d;
            violation_q  <= violation_d;
        end
    end

endmodule

// File: rtl/cmd_turnaround_tracker.sv
// Multi-channel CMD bus turnaround tracker: one independent channel tracker
// per CMD/data bus, exposing reqFree/busQuiet/violation per channel.
module cmd_turnaround_tracker
    import cmd_turnaround_pkg::*;
#(
    parameter int  NUM_CHANNELS = 2,
    parameter int  NUM_RANKS    = 4,
    parameter int  tRTRS        = 2,
    parameter int  tRTW         = 4,
    parameter int  tWTR         = 6,
    localparam int RANK_W       = rank_width(NUM_RANKS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS-1:0]              issueValid,
    input  logic [NUM_CHANNELS-1:0][RANK_W-1:0]  issueRank,
    input  logic [NUM_CHANNELS-1:0]              issueIsWrite,
    input  logic [NUM_CHANNELS-1:0][RANK_W-1:0]  reqRank,
    input  logic [NUM_CHANNELS-1:0]              reqIsWrite,
    output logic [NUM_CHANNELS-1:0]              reqFree,
    output logic [NUM_CHANNELS-1:0]              busQuiet,
    output logic [NUM_CHANNELS-1:0]              violation
);

    // One tracker per channel; channels share nothing.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        cmd_turnaround_channel #(
            .NUM_RANKS (NUM_RANKS),
            .tRTRS     (tRTRS),
            .tRTW      (tRTW),
            .tWTR      (tWTR)
        ) u_ch (
            .clk              (clk),
            .rst              (rst),
            .issue_valid_i    (issueValid[c]),
            .issue_rank_i     (issueRank[c]),
            .issue_is_write_i (issueIsWrite[c]),
            .req_rank_i       (reqRank[c]),
            .req_is_write_i   (reqIsWrite[c]),
            .req_free_o       (reqFree[c]),
            .bus_quiet_o      (busQuiet[c]),
            .violation_o      (violation[c])
        );
    end

endmodule
